// File: rtl/vertibi_decoder.sv
// Hard-decision Viterbi decoder, rate 1/2, K=3, generators (7,5) octal.
// Decodes back-to-back 8-symbol frames with register-exchange survivor paths.
module vertibi_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Signal,
  output logic [7:0] DataOut
);

  localparam logic [4:0] PmInit = 5'd16;
  localparam logic [4:0] PmMax  = 5'd31;

  logic [4:0] pm_q   [4];
  logic [4:0] pm_d   [4];
  logic [7:0] path_q [4];
  logic [7:0] path_d [4];
  logic [2:0] cnt_q;
  logic [7:0] data_out_q;

  logic [1:0] pred0 [4];
  logic [1:0] pred1 [4];
  logic [4:0] cand0 [4];
  logic [4:0] cand1 [4];
  logic [1:0] best;
  logic [4:0] best_pm;

  // Hamming distance between the received symbol and the branch's encoder output.
  function automatic logic [1:0] branch_metric(input logic [1:0] st, input logic u,
                                               input logic [1:0] sym);
    logic [1:0] exp_sym;
    logic [1:0] diff;
    exp_sym = {u ^ st[1] ^ st[0], u ^ st[0]};
    diff    = exp_sym ^ sym;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  function automatic logic [4:0] sat_add(input logic [4:0] pm, input logic [1:0] bm);
    logic [5:0] sum;
    sum = {1'b0, pm} + {4'b0000, bm};
    return (sum > {1'b0, PmMax}) ? PmMax : sum[4:0];
  endfunction

  always_comb begin
    for (int ns = 0; ns < 4; ns++) begin
      pred0[ns] = {ns[0], 1'b0};
      pred1[ns] = {ns[0], 1'b1};
      cand0[ns] = sat_add(pm_q[pred0[ns]], branch_metric(pred0[ns], ns[1], Signal));
      cand1[ns] = sat_add(pm_q[pred1[ns]], branch_metric(pred1[ns], ns[1], Signal));
      // Ties keep the even predecessor.
      if (cand1[ns] < cand0[ns]) begin
        pm_d[ns]   = cand1[ns];
        path_d[ns] = {path_q[pred1[ns]][6:0], ns[1]};
      end else begin
        pm_d[ns]   = cand0[ns];
        path_d[ns] = {path_q[pred0[ns]][6:0], ns[1]};
      end
    end
  end

  always_comb begin
    best    = 2'd0;
    best_pm = pm_d[0];
    for (int i = 1; i < 4; i++) begin
      if (pm_d[i] < best_pm) begin
        best    = 2'(i);
        best_pm = pm_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 3'd0;
      data_out_q <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= (i == 0) ? 5'd0 : PmInit;
        path_q[i] <= 8'h00;
      end
    end else begin
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        data_out_q <= path_d[best];
        for (int i = 0; i < 4; i++) begin
          pm_q[i]   <= (i == 0) ? 5'd0 : PmInit;
          path_q[i] <= 8'h00;
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          pm_q[i]   <= pm_d[i];
          path_q[i] <= path_d[i];
        end
      end
    end
  end

  assign DataOut = data_out_q;

endmodule

// File: tb/tb_vertibi_decoder.sv
// Bench for vertibi_decoder: directed frame table plus random codewords checked
// against a brute-force maximum-likelihood decoder over all 256 messages.
module tb_vertibi_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] Signal;
  logic [7:0] DataOut;

  int checks   = 0;
  int failures = 0;

  vertibi_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .Signal (Signal),
    .DataOut(DataOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] syms;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: DataOut=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives one frame; DataOut must keep the previous frame's result until the last edge.
  task automatic send_frame(input logic [15:0] syms, input logic hold_valid,
                            input logic [7:0] hold_exp, input string name);
    for (int i = 0; i < 8; i++) begin
      Signal = syms[15-2*i -: 2];
      @(posedge clk);
      #1;
      if (hold_valid && i < 7) check({name, "_hold"}, DataOut, hold_exp);
    end
  endtask

  // Convolutional encoder straight from the generator polynomials 111 and 101.
  function automatic logic [15:0] encode(input logic [7:0] d);
    logic [15:0] e;
    logic b, b1, b2;
    b1 = 1'b0;
    b2 = 1'b0;
    e  = '0;
    for (int k = 0; k < 8; k++) begin
      b          = d[7-k];
      e[15-2*k]  = b ^ b1 ^ b2;
      e[14-2*k]  = b ^ b2;
      b2         = b1;
      b1         = b;
    end
    return e;
  endfunction

  vec_t vecs[5];
  logic [7:0] prev;

  initial begin
    vecs[0] = '{16'b11_10_11_00_00_00_00_00, 8'h80, "frame_80"};
    vecs[1] = '{16'b00_00_00_00_00_00_00_00, 8'h00, "all_zero"};
    vecs[2] = '{16'b11_10_00_01_01_11_00_00, 8'hB0, "clean_b0"};
    vecs[3] = '{16'b11_10_10_01_01_11_00_00, 8'hB0, "one_err_b0"};
    vecs[4] = '{16'b00_00_00_00_00_00_00_00, 8'h00, "zero_after_b0"};

    rst    = 1'b1;
    Signal = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset", DataOut, 8'h00);
    rst = 1'b0;

    prev = 8'h00;
    foreach (vecs[k]) begin
      send_frame(vecs[k].syms, 1'b1, prev, vecs[k].name);
      check(vecs[k].name, DataOut, vecs[k].exp);
      prev = vecs[k].exp;
    end

    // Mid-frame reset discards the partial frame; the next edge starts a fresh frame.
    for (int i = 0; i < 4; i++) begin
      Signal = vecs[2].syms[15-2*i -: 2];
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midframe_reset", DataOut, 8'h00);
    rst = 1'b0;
    send_frame(vecs[2].syms, 1'b1, 8'h00, "after_reset");
    check("after_reset_b0", DataOut, 8'hB0);

    // Random codewords with up to two bit errors, checked when the ML decision is unique.
    prev = 8'hB0;
    begin
      logic        prev_ok;
      logic [7:0]  data;
      logic [15:0] rx;
      int          best_d, n_best, d;
      logic [7:0]  ml;
      prev_ok = 1'b1;
      for (int f = 0; f < 40; f++) begin
        data = 8'($urandom);
        rx   = encode(data);
        for (int e = $urandom_range(0, 2); e > 0; e--) rx[$urandom_range(0, 15)] ^= 1'b1;
        best_d = 99;
        n_best = 0;
        ml     = 8'h00;
        for (int c = 0; c < 256; c++) begin
          d = $countones(encode(8'(c)) ^ rx);
          if (d < best_d) begin
            best_d = d;
            n_best = 1;
            ml     = 8'(c);
          end else if (d == best_d) begin
            n_best++;
          end
        end
        send_frame(rx, prev_ok, prev, "rand");
        if (n_best == 1 && best_d < 16) begin
          check("rand_frame", DataOut, ml);
          prev    = ml;
          prev_ok = 1'b1;
        end else begin
          prev_ok = 1'b0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
